fetch_seq: RTL

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq_if.sv | 40 ++++
 rtl/fetch_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_seq_if.sv
// Fetch sequencer bus bundle: PC generator, pipeline redirect, instruction memory and status.
// Trap signals exist only when FETCH_SEQ_TRAP_EN is defined.
interface fetch_seq_if;
   logic [31:0] pc_i;
   logic        pcStall_o;
   logic        pcBr_o;
   logic [31:0] pcBrPC_o;
   logic [31:0] pcOffset_o;
   logic        hazardStall_i;
   logic        brTaken_i;
   logic [31:0] brPC_i;
   logic [31:0] brOffset_i;
`ifdef FETCH_SEQ_TRAP_EN
   logic        trap_i;
   logic [31:0] trapVec_i;
`endif
   logic        imemReq_o;
   logic [31:0] imemAddr_o;
   logic        imemAck_i;
   logic        flush_o;
   logic        timeout_o;

   modport master (
      input  pc_i, hazardStall_i, brTaken_i, brPC_i, brOffset_i, imemAck_i,
`ifdef FETCH_SEQ_TRAP_EN
      input  trap_i, trapVec_i,
`endif
      output pcStall_o, pcBr_o, pcBrPC_o, pcOffset_o, imemReq_o, imemAddr_o,
      output flush_o, timeout_o
   );

   modport slave (
      output pc_i, hazardStall_i, brTaken_i, brPC_i, brOffset_i, imemAck_i,
`ifdef FETCH_SEQ_TRAP_EN
      output trap_i, trapVec_i,
`endif
      input  pcStall_o, pcBr_o, pcBrPC_o, pcOffset_o, imemReq_o, imemAddr_o,
      input  flush_o, timeout_o
   );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: IDLE/FETCH/PEND FSM with deferred redirects and a sticky wait timeout.
// Optional trap redirects are enabled by defining FETCH_SEQ_TRAP_EN.
module fetch_seq (
   input  logic       clk_i,
   input  logic       rst_i,
   fetch_seq_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, PEND} state_t;

   state_t      state_q, state_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] pend_off_q, pend_off_d;
   logic [4:0]  wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;
`ifdef FETCH_SEQ_TRAP_EN
   logic        pend_trap_q, pend_trap_d;
   logic        new_trap, mrg_trap;
`endif

   logic        redir, take_new;
   logic [31:0] new_pc, new_off, mrg_pc, mrg_off;

   logic        req, stall, br, flush;
   logic [31:0] addr, br_pc, br_off;

   // New redirect target, and the pending target after merging with it.
   always_comb begin
`ifdef FETCH_SEQ_TRAP_EN
      redir    = bus.trap_i | bus.brTaken_i;
      new_trap = bus.trap_i;
      new_pc   = bus.trap_i ? bus.trapVec_i : bus.brPC_i;
      new_off  = bus.trap_i ? '0 : bus.brOffset_i;
      take_new = redir && !(pend_trap_q && !bus.trap_i);
      mrg_trap = take_new ? new_trap : pend_trap_q;
`else
      redir    = bus.brTaken_i;
      new_pc   = bus.brPC_i;
      new_off  = bus.brOffset_i;
      take_new = redir;
`endif
      mrg_pc  = take_new ? new_pc  : pend_pc_q;
      mrg_off = take_new ? new_off : pend_off_q;
   end

   always_comb begin
      state_d    = state_q;
      pend_pc_d  = pend_pc_q;
      pend_off_d = pend_off_q;
`ifdef FETCH_SEQ_TRAP_EN
      pend_trap_d = pend_trap_q;
`endif
      req    = 1'b0;
      addr   = '0;
      stall  = 1'b1;
      br     = 1'b0;
      br_pc  = '0;
      br_off = '0;
      flush  = 1'b0;

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            req  = 1'b1;
            addr = bus.pc_i;
            if (redir && bus.imemAck_i) begin
               br     = 1'b1;
               stall  = 1'b0;
               flush  = 1'b1;
               br_pc  = new_pc;
               br_off = new_off;
            end else if (redir) begin
               pend_pc_d  = new_pc;
               pend_off_d = new_off;
`ifdef FETCH_SEQ_TRAP_EN
               pend_trap_d = new_trap;
`endif
               state_d = PEND;
            end else begin
               stall = !bus.imemAck_i | bus.hazardStall_i;
            end
         end
         PEND: begin
            req  = 1'b1;
            addr = bus.pc_i;
            if (bus.imemAck_i) begin
               br         = 1'b1;
               stall      = 1'b0;
               flush      = 1'b1;
               br_pc      = mrg_pc;
               br_off     = mrg_off;
               pend_pc_d  = '0;
               pend_off_d = '0;
`ifdef FETCH_SEQ_TRAP_EN
               pend_trap_d = 1'b0;
`endif
               state_d = FETCH;
            end else begin
               pend_pc_d  = mrg_pc;
               pend_off_d = mrg_off;
`ifdef FETCH_SEQ_TRAP_EN
               pend_trap_d = mrg_trap;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // IDLE always leads into FETCH, so clearing here covers the entry case.
      if (state_q == IDLE || bus.imemAck_i)
         wait_cnt_d = '0;
      else if (wait_cnt_q != 5'd31)
         wait_cnt_d = wait_cnt_q + 5'd1;
      else
         wait_cnt_d = wait_cnt_q;
      timeout_d = timeout_q | (wait_cnt_d == 5'd16);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         pend_pc_q  <= '0;
         pend_off_q <= '0;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
`ifdef FETCH_SEQ_TRAP_EN
         pend_trap_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pend_pc_q  <= pend_pc_d;
         pend_off_q <= pend_off_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
`ifdef FETCH_SEQ_TRAP_EN
         pend_trap_q <= pend_trap_d;
`endif
      end
   end

   assign bus.imemReq_o  = req;
   assign bus.imemAddr_o = addr;
   assign bus.pcStall_o  = stall;
   assign bus.pcBr_o     = br;
   assign bus.pcBrPC_o   = br_pc;
   assign bus.pcOffset_o = br_off;
   assign bus.flush_o    = flush;
   assign bus.timeout_o  = timeout_q;
endmodule
